alu_result_stage: RTL

//   Output stage directly downstream of the 32-bit ALU datapath (the per-bit logic units and their
//   4:1 result muxes). Captures each ALU result together with the op code that produced it.

---
 rtl/alu_result_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Output stage behind the 32-bit ALU datapath. Each accepted ALU result is
//   captured with its op code and carry, and its zero/negative/parity flags
//   are computed at capture time. Everything goes into a small FIFO so the
//   downstream consumer can stall without back-pressuring ALU issue.
//
//   Handshake: a transfer happens on a rising edge when valid and ready are
//   both high on that side (push = in_valid_i & in_ready_o, pop =
//   out_valid_o & out_ready_i). Valid never depends on ready. in_ready_o is
//   derived only from the registered occupancy and rst_ni, so out_ready_i
//   has no combinational path to in_ready_o: a full FIFO refuses a push
//   even in a cycle where it is being popped.
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         result_i,
  input  logic [1:0]               op_i,
  input  logic                     carry_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         result_o,
  output logic [1:0]               op_o,
  output logic                     zero_o,
  output logic                     neg_o,
  output logic                     carry_o,
  output logic                     parity_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Entry storage, one slot per FIFO position.
  logic [WIDTH-1:0] r_mem_result [DEPTH];
  logic [1:0]       r_mem_op     [DEPTH];
  logic             r_mem_carry  [DEPTH];
  logic             r_mem_zero   [DEPTH];
  logic             r_mem_neg    [DEPTH];
  logic             r_mem_parity [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_zero;
  logic             w_neg;
  logic             w_parity;

  // Status flags of the incoming result, captured alongside it.
  assign w_zero   = ~|result_i;
  assign w_neg    = result_i[WIDTH-1];
  assign w_parity = ^result_i;

  assign w_full   = (r_level == FULL_LVL);
  assign w_empty  = (r_level == '0);

  assign in_ready_o  = ~w_full & rst_ni;
  assign out_valid_o = ~w_empty;

  assign w_push = in_valid_i & in_ready_o;
  assign w_pop  = out_valid_o & out_ready_i;

  // Write the accepted result and its flags into the slot at the write pointer.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_result[r_wr_ptr] <= result_i;
      r_mem_op[r_wr_ptr]     <= op_i;
      r_mem_carry[r_wr_ptr]  <= carry_i;
      r_mem_zero[r_wr_ptr]   <= w_zero;
      r_mem_neg[r_wr_ptr]    <= w_neg;
      r_mem_parity[r_wr_ptr] <= w_parity;
    end
  end

  // Write pointer advances on every push; reset discards all entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances on every pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: up on push only, down on pop only, unchanged on both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Delivered-result counter, free-running wrap on overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (w_pop) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  // Head entry is presented only while valid; otherwise all data reads as 0.
  // Since r_level clears asynchronously, the outputs drop as soon as reset hits.
  always_comb begin
    result_o = '0;
    op_o     = '0;
    carry_o  = 1'b0;
    zero_o   = 1'b0;
    neg_o    = 1'b0;
    parity_o = 1'b0;
    if (out_valid_o) begin
      result_o = r_mem_result[r_rd_ptr];
      op_o     = r_mem_op[r_rd_ptr];
      carry_o  = r_mem_carry[r_rd_ptr];
      zero_o   = r_mem_zero[r_rd_ptr];
      neg_o    = r_mem_neg[r_rd_ptr];
      parity_o = r_mem_parity[r_rd_ptr];
    end
  end

  assign level_o = r_level;
  assign count_o = r_count;

endmodule
